mbisr_repair_alloc: RTL

Redundancy allocation and address-remap stage that sits directly downstream of the MBIST controller in the `tt_um_aksp_mbist_mbisr` design. During a test run it captures unique failing row addresses reported by MBIST into a small spare-row CAM. At end of test it declares the memory repaired or unrepairable. Afterwards it remaps accesses to failing rows onto spare rows.

---
 rtl/mbisr_repair_alloc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mbisr_repair_alloc.sv
// -----------------------------------------------------------------------------
// mbisr_repair_alloc
//
// Redundancy allocation and address remap stage that sits downstream of the
// MBIST controller. While a test runs, unique failing row addresses are
// captured into a small spare-row CAM in order of first occurrence. When MBIST
// reports done, the block declares the memory REPAIRED (every fail fits in a
// spare) or UNREPAIRABLE (more distinct fails than spares). In REPAIRED,
// functional accesses that hit a captured row are reported with the spare row
// index that replaces it.
//
// Ports:
//   clk            single clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   collect_start  one-cycle pulse: clear CAM and start fail collection
//   fail_valid     MBIST fail strobe, one failing read per asserted cycle
//   fail_addr      failing row address, qualified by fail_valid
//   bist_done      MBIST completion, ends collection
//   acc_addr       functional access address to remap
//   busy           high while collecting
//   repair_ok      high in REPAIRED
//   repair_fail    high in UNREPAIRABLE
//   spare_used     number of valid CAM entries (saturates at SPARES)
//   remap_hit      registered: acc_addr hit a repaired row
//   remap_idx      registered: spare index for the hit, 0 otherwise
// -----------------------------------------------------------------------------
module mbisr_repair_alloc #(
  parameter  int ADDR_W = 5,
  parameter  int SPARES = 4,
  parameter  int CNT_W  = $clog2(SPARES + 1),
  localparam int IDX_W  = (SPARES > 1) ? $clog2(SPARES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              collect_start,
  input  logic              fail_valid,
  input  logic [ADDR_W-1:0] fail_addr,
  input  logic              bist_done,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic              busy,
  output logic              repair_ok,
  output logic              repair_fail,
  output logic [CNT_W-1:0]  spare_used,
  output logic              remap_hit,
  output logic [IDX_W-1:0]  remap_idx
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    COLLECT      = 2'd1,
    REPAIRED     = 2'd2,
    UNREPAIRABLE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] SPARES_C = CNT_W'(SPARES);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  entry_q [SPARES];
  logic [ADDR_W-1:0]  entry_d [SPARES];
  logic [SPARES-1:0]  valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               remap_hit_q, remap_hit_d;
  logic [IDX_W-1:0]   remap_idx_q, remap_idx_d;

  logic               fail_match;
  logic               acc_match;
  logic [IDX_W-1:0]   acc_idx;

  // CAM lookups. Dedupe guarantees at most one valid entry matches any
  // address, so the index search needs no priority resolution.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    fail_match = 1'b0;
    acc_match  = 1'b0;
    acc_idx    = '0;
    for (int i = 0; i < SPARES; i++) begin
      if (valid_q[i] && (entry_q[i] == fail_addr)) begin
        fail_match = 1'b1;
      end
      if (valid_q[i] && (entry_q[i] == acc_addr)) begin
        acc_match = 1'b1;
        acc_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state, CAM update and remap.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    remap_hit_d = 1'b0;
    remap_idx_d = '0;

    if (collect_start) begin
      // Restart wins over any fail or done strobe in the same cycle.
      state_d = COLLECT;
      valid_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (state_q == COLLECT) begin
      if (fail_valid && !fail_match) begin
        if (cnt_q < SPARES_C) begin
          for (int i = 0; i < SPARES; i++) begin
            if (CNT_W'(i) == cnt_q) begin
              entry_d[i] = fail_addr;
              valid_d[i] = 1'b1;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      // A fail in the done cycle is already folded into ovf_d here.
      if (bist_done) begin
        state_d = ovf_d ? UNREPAIRABLE : REPAIRED;
      end
    end

    // Remap uses the registered state, so the first lookup is the edge after
    // REPAIRED has been entered.
    if ((state_q == REPAIRED) && acc_match) begin
      remap_hit_d = 1'b1;
      remap_idx_d = acc_idx;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      remap_hit_q <= 1'b0;
      remap_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      remap_hit_q <= remap_hit_d;
      remap_idx_q <= remap_idx_d;
    end
  end

  // NOTE: CAM address storage is deliberately not reset; the valid bits
  // qualify every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  assign busy        = (state_q == COLLECT);
  assign repair_ok   = (state_q == REPAIRED);
  assign repair_fail = (state_q == UNREPAIRABLE);
  assign spare_used  = cnt_q;
  assign remap_hit   = remap_hit_q;
  assign remap_idx   = remap_idx_q;

endmodule
